// File: rtl/bolt_shot_ctrl.sv
// bolt_shot_ctrl: launch-side controller that arms, fires and ends a single player bolt
//   clk, reset          system clock, synchronous active-high reset
//   startOfFrame        one-clk pulse per frame (drives cooldown and flight timeout)
//   enable              game running; low aborts to IDLE
//   fireKey             synchronised fire button level
//   boltHit, boltY      collision flag and Y position from the bolt mover
//   shootCmd            1 = mover integrates, 0 = mover tracks the launch point
//   boltVisible         bolt sprite drawing enable
//   shotFired, shotHit  one-clk launch and collision pulses
//   shotCount           launched shots, modulo 256
module bolt_shot_ctrl #(
    parameter logic [10:0] TOP_LIMIT       = 11'd16,
    parameter logic [10:0] WRAP_LIMIT      = 11'd1024,
    parameter logic [7:0]  COOLDOWN_FRAMES = 8'd6,
    parameter logic [7:0]  MAX_FLIGHT      = 8'd60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        fireKey,
    input  logic        boltHit,
    input  logic [10:0] boltY,
    output logic        shootCmd,
    output logic        boltVisible,
    output logic        shotFired,
    output logic        shotHit,
    output logic [7:0]  shotCount
);
    typedef enum logic [1:0] {IDLE, FLY, COOL} state_t;
    state_t state, state_n;
    logic fire_key_d, first_fly, fire_edge, out_of_bounds, go_fire, go_hit;
    logic [7:0] flight_cnt, flight_cnt_n, cool_cnt, cool_cnt_n;
    assign fire_edge     = fireKey & ~fire_key_d;
    assign out_of_bounds = (boltY <= TOP_LIMIT) || (boltY >= WRAP_LIMIT);
    always_comb begin
        state_n      = state;
        go_fire      = 1'b0;
        go_hit       = 1'b0;
        flight_cnt_n = flight_cnt;
        cool_cnt_n   = cool_cnt;
        case (state)
            IDLE: begin
                if (enable && fire_edge) begin
                    state_n      = FLY;
                    go_fire      = 1'b1;
                    flight_cnt_n = 8'd0;
                end
            end
            FLY: begin
                if (startOfFrame && flight_cnt != MAX_FLIGHT)
                    flight_cnt_n = flight_cnt + 8'd1;
                // boltY still holds the launch point on the first FLY clk
                if (!enable)
                    state_n = IDLE;
                else if (!first_fly) begin
                    if (boltHit) begin
                        state_n = COOL;
                        go_hit  = 1'b1;
                    end else if (out_of_bounds || flight_cnt >= MAX_FLIGHT)
                        state_n = COOL;
                end
                if (state_n == COOL)
                    cool_cnt_n = COOLDOWN_FRAMES;
            end
            COOL: begin
                if (!enable || cool_cnt == 8'd0)
                    state_n = IDLE;
                else if (startOfFrame)
                    cool_cnt_n = cool_cnt - 8'd1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shootCmd    <= 1'b0;
            boltVisible <= 1'b0;
            shotFired   <= 1'b0;
            shotHit     <= 1'b0;
            shotCount   <= 8'd0;
            flight_cnt  <= 8'd0;
            cool_cnt    <= 8'd0;
            first_fly   <= 1'b0;
            fire_key_d  <= 1'b1;
        end else begin
            state       <= state_n;
            shootCmd    <= state_n == FLY;
            boltVisible <= state_n == FLY;
            shotFired   <= go_fire;
            shotHit     <= go_hit;
            shotCount   <= shotCount + {7'd0, go_fire};
            flight_cnt  <= flight_cnt_n;
            cool_cnt    <= cool_cnt_n;
            first_fly   <= go_fire;
            fire_key_d  <= fireKey;
        end
    end
endmodule

// File: tb/tb_bolt_shot_ctrl.sv
// tb_bolt_shot_ctrl: directed bench with an event scoreboard for bolt_shot_ctrl
module tb_bolt_shot_ctrl;
    logic clk = 1'b0;
    logic reset, startOfFrame, enable, fireKey, boltHit;
    logic [10:0] boltY;
    logic shootCmd, boltVisible, shotFired, shotHit;
    logic [7:0] shotCount;
    typedef struct {logic hit; logic [7:0] cnt;} ev_t;
    ev_t exp_q[$];
    int compared = 0;
    int mismatched = 0;
    logic [7:0] cnt_model = 8'd0;
    bolt_shot_ctrl dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
        .fireKey(fireKey), .boltHit(boltHit), .boltY(boltY), .shootCmd(shootCmd),
        .boltVisible(boltVisible), .shotFired(shotFired), .shotHit(shotHit),
        .shotCount(shotCount)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (shotFired || shotHit) begin
            check("pulse_exclusive", int'(shotFired & shotHit), 0);
            if (exp_q.size() == 0)
                check("unexpected_pulse", {shotHit, shotFired}, 0);
            else begin
                ev_t e;
                e = exp_q.pop_front();
                check("pulse_kind_is_hit", int'(shotHit), int'(e.hit));
                check("pulse_shot_count", int'(shotCount), int'(e.cnt));
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic sof();
        startOfFrame = 1'b1;
        tick(1);
        startOfFrame = 1'b0;
        tick(1);
    endtask
    task automatic fire_shot();
        fireKey = 1'b0;
        tick(1);
        cnt_model = cnt_model + 8'd1;
        exp_q.push_back('{1'b0, cnt_model});
        fireKey = 1'b1;
        tick(1);
    endtask
    task automatic dead_fire();
        fireKey = 1'b0;
        tick(1);
        fireKey = 1'b1;
        tick(1);
    endtask
    task automatic cool_wait();
        repeat (6) sof();
        tick(1);
    endtask
    initial begin
        reset = 1'b1; fireKey = 1'b1; enable = 1'b1; startOfFrame = 1'b0;
        boltHit = 1'b0; boltY = 11'd400;
        tick(3);
        reset = 1'b0;
        tick(3);
        check("reset_shootCmd", shootCmd, 0);
        check("reset_boltVisible", boltVisible, 0);
        check("reset_shotCount", shotCount, 0);
        fireKey = 1'b0;
        tick(2);
        check("no_launch_on_release", shootCmd, 0);
        cnt_model = 8'd1;
        exp_q.push_back('{1'b0, 8'd1});
        fireKey = 1'b1;
        tick(1);
        check("launch_shootCmd", shootCmd, 1);
        check("launch_boltVisible", boltVisible, 1);
        check("launch_count", shotCount, 1);
        tick(1);
        boltY = 11'd16;
        tick(1);
        check("top_exit_shootCmd", shootCmd, 0);
        check("top_exit_visible", boltVisible, 0);
        dead_fire();
        check("cool_fire_dropped", shotCount, 1);
        repeat (5) sof();
        dead_fire();
        check("cool_5_frames_dropped", shootCmd, 0);
        sof();
        boltY = 11'd400;
        tick(1);
        fire_shot();
        check("after_cooldown_launch", shootCmd, 1);
        check("after_cooldown_count", shotCount, 2);
        tick(1);
        dead_fire();
        check("fly_fire_dropped", shotCount, 2);
        check("fly_still_flying", shootCmd, 1);
        exp_q.push_back('{1'b1, 8'd2});
        boltHit = 1'b1; boltY = 11'd10;
        tick(1);
        boltHit = 1'b0; boltY = 11'd400;
        check("hit_exit_shootCmd", shootCmd, 0);
        tick(2);
        cool_wait();
        fire_shot();
        boltY = 11'd300;
        repeat (59) sof();
        check("flight_59_frames", shootCmd, 1);
        sof();
        check("flight_timeout", shootCmd, 0);
        boltY = 11'd400;
        cool_wait();
        fire_shot();
        tick(1);
        boltY = 11'd17;
        tick(1);
        check("y17_stays", shootCmd, 1);
        boltY = 11'd1023;
        tick(1);
        check("y1023_stays", shootCmd, 1);
        boltY = 11'd1024;
        tick(1);
        check("y1024_exit", shootCmd, 0);
        boltY = 11'd400;
        cool_wait();
        fire_shot();
        tick(1);
        boltY = 11'd2040;
        tick(1);
        check("wrap_exit", shootCmd, 0);
        boltY = 11'd400;
        cool_wait();
        fire_shot();
        tick(1);
        enable = 1'b0;
        tick(1);
        check("abort_shootCmd", shootCmd, 0);
        enable = 1'b1;
        fire_shot();
        check("abort_to_idle_refire", shootCmd, 1);
        tick(1);
        boltY = 11'd16;
        tick(1);
        enable = 1'b0;
        tick(1);
        dead_fire();
        check("disabled_no_fire", shotCount, int'(cnt_model));
        enable = 1'b1; boltY = 11'd400;
        fire_shot();
        tick(1);
        boltY = 11'd5;
        tick(1);
        check("pre_reset_cool", shootCmd, 0);
        reset = 1'b1;
        tick(1);
        check("mid_cool_reset_count", shotCount, 0);
        check("mid_cool_reset_shootCmd", shootCmd, 0);
        check("mid_cool_reset_visible", boltVisible, 0);
        reset = 1'b0; boltY = 11'd400; cnt_model = 8'd0;
        tick(1);
        for (int i = 0; i < 256; i++) begin
            fire_shot();
            tick(1);
            boltY = 11'd5;
            tick(1);
            enable = 1'b0;
            tick(1);
            enable = 1'b1; boltY = 11'd400;
        end
        check("count_wrap_256", shotCount, 0);
        tick(4);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
